// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  localparam int WORD_W      = 32;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_LATENCY = 2;
  localparam int MAX_LATENCY = 15;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Rejects byte addresses that are not word aligned or fall beyond the RAM.
  function automatic logic addr_err(input logic [WORD_W-1:0] addr,
                                    input int unsigned       addr_w);
    logic misaligned;
    logic out_of_range;
    misaligned   = (addr[1:0] != 2'b00);
    out_of_range = ((addr >> (addr_w + 2)) != '0);
    return misaligned | out_of_range;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data RAM: synchronous write, combinational read, no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Request/acknowledge data-memory responder with a fixed multi-cycle latency.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_wr,
  input  logic [WORD_W-1:0] i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata,
  output logic              o_ack,
  output logic              o_err,
  output logic              o_busy
);

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("dmem_responder: LATENCY must lie within 1..15");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic              w_accept;
  logic              w_done;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_wr;
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [WORD_W-1:0] r_rdata;
  logic              r_err;
  logic              w_err_next;
  logic              w_we;
  logic [WORD_W-1:0] w_mem_rdata;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req) begin
          w_accept     = 1'b1;
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_done       = 1'b1;
          w_state_next = RESP;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // The error decision and the commit both use the request latched at accept.
  assign w_err_next = addr_err(r_addr, ADDR_W);
  assign w_we       = w_done & r_wr & ~w_err_next;

  dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_addr  (r_addr[ADDR_W+1:2]),
    .i_wdata (r_wdata),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= CNT_LOAD;
        r_wr    <= i_wr;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end else if (r_state == WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_done) begin
        r_err   <= w_err_next;
        r_rdata <= (w_err_next | r_wr) ? '0 : w_mem_rdata;
      end
    end
  end

  assign o_rdata = r_rdata;
  assign o_err   = r_err;
  assign o_ack   = (r_state == RESP);
  assign o_busy  = (r_state != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder at LATENCY 2, 1 and 15.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_wr;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [2:0]  req_v;
  logic [2:0]  ack_v;
  logic [2:0]  err_v;
  logic [2:0]  busy_v;
  logic [31:0] rdata_a [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // index 0: LATENCY=2, index 1: LATENCY=1, index 2: LATENCY=15
  dmem_responder #(.ADDR_W(8), .LATENCY(2)) u_l2 (
    .i_clk(clk), .i_rst(i_rst), .i_req(req_v[0]), .i_wr(i_wr), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_rdata(rdata_a[0]), .o_ack(ack_v[0]), .o_err(err_v[0]),
    .o_busy(busy_v[0]));

  dmem_responder #(.ADDR_W(8), .LATENCY(1)) u_l1 (
    .i_clk(clk), .i_rst(i_rst), .i_req(req_v[1]), .i_wr(i_wr), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_rdata(rdata_a[1]), .o_ack(ack_v[1]), .o_err(err_v[1]),
    .o_busy(busy_v[1]));

  dmem_responder #(.ADDR_W(8), .LATENCY(15)) u_l15 (
    .i_clk(clk), .i_rst(i_rst), .i_req(req_v[2]), .i_wr(i_wr), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_rdata(rdata_a[2]), .o_ack(ack_v[2]), .o_err(err_v[2]),
    .o_busy(busy_v[2]));

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  // cycles = negedges from request drive to Ack (LATENCY+1), 0 on timeout.
  task automatic access(input int sel, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic scramble,
                        output int cycles, output logic [31:0] rd, output logic er);
    int n;
    n      = 0;
    cycles = 0;
    rd     = 'x;
    er     = 1'bx;
    i_wr = wr; i_addr = addr; i_wdata = wdata; req_v[sel] = 1'b1;
    while (n < 40 && cycles == 0) begin
      @(negedge clk);
      n++;
      if (scramble && n == 1) begin
        i_wr = ~wr; i_addr = addr ^ 32'h0000_0404; i_wdata = ~wdata;
      end
      if (ack_v[sel]) begin
        cycles = n;
        rd     = rdata_a[sel];
        er     = err_v[sel];
      end
    end
    req_v[sel] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({ack_v[k], err_v[k], busy_v[k]} !== 3'b000 || rdata_a[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: ack/err/busy=%b%b%b rdata=%h, required 000 / 0",
                 k, ack_v[k], err_v[k], busy_v[k], rdata_a[k]);
      end
    end
  endtask

  task automatic test_store_load();
    int c; logic [31:0] rd; logic er;
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, c, rd, er);
    $display("store 0x10 <= deadbeef: cycles=%0d err=%b rdata=%h", c, er, rd);
    n_checks++;
    if (c !== 3 || er !== 1'b0 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL store_0x10: cycles=%0d err=%b rdata=%h, required 3 0 00000000", c, er, rd);
    end
    access(0, 1'b0, 32'h10, 32'h0, 1'b0, c, rd, er);
    $display("load 0x10: cycles=%0d err=%b rdata=%h", c, er, rd);
    n_checks++;
    if (c !== 3 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL load_0x10: cycles=%0d err=%b rdata=%h, required 3 0 deadbeef", c, er, rd);
    end
    access(0, 1'b1, 32'h3FC, 32'h0BADF00D, 1'b0, c, rd, er);
    access(0, 1'b0, 32'h3FC, 32'h0, 1'b0, c, rd, er);
    $display("load 0x3fc (top word): cycles=%0d err=%b rdata=%h", c, er, rd);
    n_checks++;
    if (c !== 3 || er !== 1'b0 || rd !== 32'h0BADF00D) begin
      n_fail++;
      $display("FAIL top_word: cycles=%0d err=%b rdata=%h, required 3 0 0badf00d", c, er, rd);
    end
  endtask

  task automatic test_errors();
    int c; logic [31:0] rd; logic er;
    access(0, 1'b1, 32'h12, 32'hCAFEF00D, 1'b0, c, rd, er);
    $display("store 0x12 (misaligned): cycles=%0d err=%b", c, er);
    n_checks++;
    if (c !== 3 || er !== 1'b1) begin
      n_fail++;
      $display("FAIL misaligned_store: cycles=%0d err=%b, required 3 1", c, er);
    end
    access(0, 1'b0, 32'h10, 32'h0, 1'b0, c, rd, er);
    $display("load 0x10 after rejected store: err=%b rdata=%h", er, rd);
    n_checks++;
    if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL word_unchanged: err=%b rdata=%h, required 0 deadbeef", er, rd);
    end
    access(0, 1'b0, 32'h400, 32'h0, 1'b0, c, rd, er);
    $display("load 0x400 (out of range): cycles=%0d err=%b rdata=%h", c, er, rd);
    n_checks++;
    if (c !== 3 || er !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL out_of_range: cycles=%0d err=%b rdata=%h, required 3 1 00000000", c, er, rd);
    end
  endtask

  task automatic test_back_to_back();
    int ack_at [3];
    int n_ack, n_idle, n_bad_data, n;
    n_ack = 0; n_idle = 0; n_bad_data = 0; n = 0;
    i_wr = 1'b0; i_addr = 32'h10; i_wdata = 32'h0; req_v[0] = 1'b1;
    while (n < 60 && n_ack < 3) begin
      @(negedge clk);
      n++;
      if (n_ack >= 1 && !busy_v[0]) n_idle++;
      if (ack_v[0]) begin
        ack_at[n_ack] = n;
        if (rdata_a[0] !== 32'hDEADBEEF) n_bad_data++;
        n_ack++;
      end
    end
    req_v[0] = 1'b0;
    @(negedge clk);
    $display("held req: acks=%0d idle_cycles=%0d bad_data=%0d", n_ack, n_idle, n_bad_data);
    n_checks++;
    if (n_ack !== 3) begin
      n_fail++;
      $display("FAIL b2b_ack_count: %0d acks, required 3", n_ack);
    end else begin
      n_checks++;
      if (ack_at[1] - ack_at[0] !== 4 || ack_at[2] - ack_at[1] !== 4 || ack_at[0] !== 3) begin
        n_fail++;
        $display("FAIL b2b_spacing: acks at %0d %0d %0d, required 3 7 11",
                 ack_at[0], ack_at[1], ack_at[2]);
      end
    end
    n_checks++;
    if (n_idle !== 2 || n_bad_data !== 0) begin
      n_fail++;
      $display("FAIL b2b_busy_data: idle=%0d bad=%0d, required 2 0", n_idle, n_bad_data);
    end
  endtask

  task automatic test_latency_extremes();
    int c; logic [31:0] rd; logic er;
    access(1, 1'b1, 32'h40, 32'h12345678, 1'b1, c, rd, er);
    access(1, 1'b0, 32'h40, 32'h0, 1'b1, c, rd, er);
    $display("lat1 load 0x40: cycles=%0d err=%b rdata=%h", c, er, rd);
    n_checks++;
    if (c !== 2 || er !== 1'b0 || rd !== 32'h12345678) begin
      n_fail++;
      $display("FAIL lat1: cycles=%0d err=%b rdata=%h, required 2 0 12345678", c, er, rd);
    end
    access(2, 1'b1, 32'h40, 32'hA5A5_5A5A, 1'b1, c, rd, er);
    n_checks++;
    if (c !== 16 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL lat15_store: cycles=%0d err=%b, required 16 0", c, er);
    end
    access(2, 1'b0, 32'h40, 32'h0, 1'b1, c, rd, er);
    $display("lat15 load 0x40: cycles=%0d err=%b rdata=%h", c, er, rd);
    n_checks++;
    if (c !== 16 || er !== 1'b0 || rd !== 32'hA5A5_5A5A) begin
      n_fail++;
      $display("FAIL lat15_load: cycles=%0d err=%b rdata=%h, required 16 0 a5a55a5a", c, er, rd);
    end
  endtask

  task automatic test_reset_mid_access();
    int c, n, n_ack; logic [31:0] rd; logic er; logic seen;
    // Reset while Ack is up with live load data: outputs must clear before the next edge.
    i_wr = 1'b0; i_addr = 32'h10; req_v[0] = 1'b1; seen = 1'b0; n = 0;
    while (n < 10 && !seen) begin
      @(negedge clk);
      n++;
      seen = ack_v[0] && rdata_a[0] == 32'hDEADBEEF;
    end
    req_v[0] = 1'b0;
    i_rst = 1'b1;
    #1;
    $display("reset in RESP: seen=%b ack=%b err=%b busy=%b rdata=%h",
             seen, ack_v[0], err_v[0], busy_v[0], rdata_a[0]);
    n_checks++;
    if (!seen || {ack_v[0], err_v[0], busy_v[0]} !== 3'b000 || rdata_a[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: seen=%b ack/err/busy=%b%b%b rdata=%h, required 1 000 0",
               seen, ack_v[0], err_v[0], busy_v[0], rdata_a[0]);
    end
    @(negedge clk);
    i_rst = 1'b0;
    access(0, 1'b0, 32'h10, 32'h0, 1'b0, c, rd, er);
    n_checks++;
    if (c !== 3 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL after_reset: cycles=%0d err=%b rdata=%h, required 3 0 deadbeef", c, er, rd);
    end
    // Reset in WAIT of a store: store discarded, no Ack.
    access(0, 1'b1, 32'h20, 32'h11111111, 1'b0, c, rd, er);
    i_wr = 1'b1; i_addr = 32'h20; i_wdata = 32'h22222222; req_v[0] = 1'b1;
    @(negedge clk);
    i_rst = 1'b1; req_v[0] = 1'b0;
    #1;
    n_checks++;
    if (busy_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_reset_busy: busy=%b, required 0", busy_v[0]);
    end
    @(negedge clk);
    i_rst = 1'b0;
    n_ack = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ack_v[0]) n_ack++;
    end
    access(0, 1'b0, 32'h20, 32'h0, 1'b0, c, rd, er);
    $display("reset in WAIT of store 0x20: stray_acks=%0d rdata=%h", n_ack, rd);
    n_checks++;
    if (n_ack !== 0 || rd !== 32'h11111111) begin
      n_fail++;
      $display("FAIL wait_reset_store: acks=%0d rdata=%h, required 0 11111111", n_ack, rd);
    end
    // Reset in RESP of a store: already committed, so it persists.
    i_wr = 1'b1; i_addr = 32'h24; i_wdata = 32'h33333333; req_v[0] = 1'b1; n = 0;
    while (n < 10 && !ack_v[0]) begin
      @(negedge clk);
      n++;
    end
    req_v[0] = 1'b0;
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    access(0, 1'b0, 32'h24, 32'h0, 1'b0, c, rd, er);
    $display("reset in RESP of store 0x24: rdata=%h", rd);
    n_checks++;
    if (rd !== 32'h33333333) begin
      n_fail++;
      $display("FAIL resp_reset_store: rdata=%h, required 33333333", rd);
    end
  endtask

  initial begin
    i_rst = 1'b1; req_v = 3'b000; i_wr = 1'b0; i_addr = '0; i_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    i_rst = 1'b0;
    @(negedge clk);
    test_store_load();
    test_errors();
    test_back_to_back();
    test_latency_extremes();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the CPU's data-memory port. Accepts one load or store per request/acknowledge handshake and models a word-addressed data RAM with a configurable multi-cycle access latency. It sits between the datapath's ALU result / Qb store-data path and the Reg2reg write-back mux. It lets the core be exercised against a non-ideal, stalling memory.

## Interface
- ADDR_W, 8: word-address width; the RAM holds 2^ADDR_W 32-bit words.
- LATENCY, 2: cycles spent in WAIT per access; legal range 1..15.
- Clk  in  1  rising-edge clock.
- Rst  in  1  asynchronous, active-high reset.
- Req  in  1  request valid; sampled only in IDLE.
- Wr  in  1  1 = store (Wmem), 0 = load; sampled with Req.
- Addr  in  32  byte address (ALU result R).
- Wdata  in  32  store data (Qb).
- Rdata  out  32  load data; valid while Ack=1.
- Ack  out  1  one-cycle completion pulse.
- Err  out  1  qualifies Ack: access rejected.
- Busy  out  1  high whenever state ≠ IDLE (stall source for PC/fetch).

One clock; reset is asynchronous and active-high.

## Operation
- States: IDLE, WAIT, RESP. Encoding is 2 bits; unused code returns to IDLE.
- IDLE: on an edge with Req=1, latch Wr, Addr, Wdata. Load the counter with LATENCY-1 and go to WAIT. With Req=0, stay.
- WAIT: on each edge, if counter = 0 go to RESP, else decrement. Req and inputs are ignored.
- Entering RESP (same edge):
  - Error check: Err_next = (Addr[1:0] ≠ 0) | (Addr[31:ADDR_W+2] ≠ 0).
  - If no error and Wr=1: write Wdata to word Addr[ADDR_W+1:2].
  - If no error and Wr=0: register that word into Rdata.
  - On error: no write, Rdata := 0.
  - For a store, Rdata := 0.
- RESP: Ack=1 for exactly one cycle, Err valid. Next edge goes to IDLE unconditionally. Req in RESP is ignored.
- Requester protocol: hold Req/Wr/Addr/Wdata stable until Ack, and drop Req in the Ack cycle. Req still high in IDLE is a new request.
- Read-after-write: a load following a store to the same word returns the new data. The store commits before the load can be accepted.

## Timing
- Reset values: state=IDLE, counter=0, Ack=0, Err=0, Rdata=0, Busy=0. RAM contents are not reset.
- Accept edge E0; Ack high in cycle after edge E0+LATENCY. Total LATENCY+1 cycles from accept to Ack; Busy high over the same span.
- Minimum request spacing is LATENCY+2 edges: accept, LATENCY WAIT edges, RESP→IDLE edge, then the next accept.
- All outputs are registered or decoded from state only; no combinational input-to-output path.
- Rst asserted mid-access (WAIT or RESP):
  - Immediate return to IDLE; Ack/Err/Rdata cleared.
  - A pending store not yet committed is discarded.
  - A store committed on the RESP entry edge persists.
- Counter width is 4 bits. Values of LATENCY outside 1..15 are illegal; the block asserts this at elaboration.

## Structure
- Shared package dmem_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - word width 32;
  - default LATENCY and ADDR_W constants;
  - the address-check function (alignment + range).
- Sub-module dmem_array: 2^ADDR_W x 32, synchronous write, combinational read, no reset. The FSM and output registers stay in dmem_responder.

## Test plan
- Reset: Rst pulse mid-run -> Ack=0, Err=0, Rdata=0, Busy=0 asynchronously. Next accepted request completes normally.
- Store then load, LATENCY=2:
  - Store 0xDEADBEEF to 0x0000_0010 -> Ack 3 cycles after accept, Err=0.
  - Load 0x10 -> Rdata=0xDEADBEEF with Ack.
- Misaligned/out of range:
  - Store to 0x0000_0012 -> Ack with Err=1; the word at 0x10 is unchanged.
  - Load 0x0000_0400 (ADDR_W=8) -> Err=1, Rdata=0.
- Held Req, back-to-back: Req held high across 3 loads -> Ack pulses exactly LATENCY+2 cycles apart. Busy low only on accept-edge IDLE cycles.
- LATENCY=1 vs 15:
  - Ack appears 2 and 16 cycles after accept respectively.
  - Inputs changed during WAIT do not affect the result.
- Reset during WAIT of a store to 0x20 -> the word at 0x20 retains its old value; no Ack is produced.
